// File: rtl/piccolo_round_sched_pkg.sv
// Shared constants and state encoding for the Piccolo round sequencer.
// Round counts, round-index width and the controller FSM states.
package piccolo_round_sched_pkg;

  localparam int RIDX_W = 5;

  localparam logic [RIDX_W-1:0] ROUNDS80  = 5'd25;
  localparam logic [RIDX_W-1:0] ROUNDS128 = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [RIDX_W-1:0] total_rounds(
    input logic ver
  );
    return ver ? ROUNDS128 : ROUNDS80;
  endfunction

endpackage

// File: rtl/piccolo_round_sched_if.sv
// Host and datapath control bundle of the Piccolo round sequencer.
// slave = sequencer side, master = host/datapath side.
interface piccolo_round_sched_if;
  import piccolo_round_sched_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_version;
  logic              out_valid;
  logic              out_ready;
  logic              dp_load;
  logic              dp_step;
  logic [RIDX_W-1:0] dp_round_base;
  logic [RIDX_W-1:0] dp_nrounds;
  logic              dp_last;
  logic              dp_version;
  logic              busy;

  modport slave (
    input  in_valid,
    input  in_version,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dp_load,
    output dp_step,
    output dp_round_base,
    output dp_nrounds,
    output dp_last,
    output dp_version,
    output busy
  );

  modport master (
    output in_valid,
    output in_version,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dp_load,
    input  dp_step,
    input  dp_round_base,
    input  dp_nrounds,
    input  dp_last,
    input  dp_version,
    input  busy
  );

endinterface

// File: rtl/piccolo_round_sched.sv
// Pass sequencer for a partially unrolled Piccolo-80/128 datapath.
// Splits the round count into passes of up to UNROLL rounds.
module piccolo_round_sched
  import piccolo_round_sched_pkg::*;
#(
  parameter int UNROLL = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  piccolo_round_sched_if.slave  bus
);

  localparam logic [5:0] U6 = 6'(UNROLL);

  state_e            state_q, state_d;
  logic [RIDX_W-1:0] base_q, base_d;
  logic [RIDX_W-1:0] rnd_q, rnd_d;
  logic              ver_q, ver_d;

  logic [5:0] remain;
  logic [5:0] nr6;
  logic [5:0] sum6;
  logic       accept;
  logic       last;

  // 6-bit arithmetic keeps base+UNROLL from wrapping
  always_comb begin
    remain = {1'b0, rnd_q} - {1'b0, base_q};
    nr6    = (remain < U6) ? remain : U6;
    sum6   = {1'b0, base_q} + nr6;
    last   = (state_q == RUN) &&
             (sum6 == {1'b0, rnd_q});
    accept = (state_q == IDLE) && bus.in_valid;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rnd_d   = rnd_q;
    ver_d   = ver_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          ver_d   = bus.in_version;
          rnd_d   = total_rounds(bus.in_version);
          base_d  = '0;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
          base_d  = '0;
        end else begin
          base_d  = base_q + U6[RIDX_W-1:0];
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        base_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      rnd_q   <= '0;
      ver_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rnd_q   <= rnd_d;
      ver_q   <= ver_d;
    end
  end

  always_comb begin
    bus.in_ready      = (state_q == IDLE);
    bus.dp_load       = accept;
    bus.dp_step       = (state_q == RUN);
    bus.dp_round_base = '0;
    bus.dp_nrounds    = '0;
    bus.dp_last       = last;
    bus.out_valid     = (state_q == DONE);
    bus.dp_version    = ver_q;
    bus.busy          = (state_q != IDLE);
    if (state_q == RUN) begin
      bus.dp_round_base = base_q;
      bus.dp_nrounds    = nr6[RIDX_W-1:0];
    end
  end

endmodule

// File: tb/tb_piccolo_round_sched.sv
// Bench for piccolo_round_sched: three instances (UNROLL 9, 16, 1)
// checked against a pass-list model derived from the round counts.
module tb_piccolo_round_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in_valid;
  logic [2:0] in_version;
  logic [2:0] out_ready;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] dp_load;
  logic [2:0] dp_step;
  logic [2:0] dp_last;
  logic [2:0] dp_version;
  logic [2:0] busy;
  logic [4:0] rb [3];
  logic [4:0] nr [3];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int U = (g == 0) ? 9 : ((g == 1) ? 16 : 1);
    piccolo_round_sched_if bus ();
    assign bus.in_valid   = in_valid[g];
    assign bus.in_version = in_version[g];
    assign bus.out_ready  = out_ready[g];
    assign in_ready[g]    = bus.in_ready;
    assign out_valid[g]   = bus.out_valid;
    assign dp_load[g]     = bus.dp_load;
    assign dp_step[g]     = bus.dp_step;
    assign dp_last[g]     = bus.dp_last;
    assign dp_version[g]  = bus.dp_version;
    assign busy[g]        = bus.busy;
    assign rb[g]          = bus.dp_round_base;
    assign nr[g]          = bus.dp_nrounds;
    piccolo_round_sched #(.UNROLL(U)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  typedef struct {
    int d;
    bit ver;
    int hold;
    bit noise;
    int exp_p;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int unroll_of(input int d);
    return (d == 0) ? 9 : ((d == 1) ? 16 : 1);
  endfunction

  function automatic int rounds_of(input bit ver);
    return ver ? 31 : 25;
  endfunction

  function automatic int n_passes(input int u, input bit ver);
    return (rounds_of(ver) + u - 1) / u;
  endfunction

  function automatic int pass_n(input int u, input bit ver, input int p);
    int left;
    left = rounds_of(ver) - p * u;
    return (left < u) ? left : u;
  endfunction

  // Entered and left at posedge+1 with the instance in IDLE.
  task automatic run_req(input int d, input bit ver, input int hold,
                         input bit noise, input int exp_p);
    int u;
    int pc;
    int np;
    u  = unroll_of(d);
    np = n_passes(u, ver);
    in_valid[d]   = 1'b1;
    in_version[d] = ver;
    out_ready[d]  = noise;
    @(negedge clk);
    chk("idle_in_ready", in_ready[d], 1);
    chk("accept_dp_load", dp_load[d], 1);
    chk("idle_busy", busy[d], 0);
    @(posedge clk); #1;
    in_valid[d]   = noise;
    in_version[d] = ~ver;
    pc = 0;
    @(negedge clk);
    while (dp_step[d] && pc < 40) begin
      chk("pass_base", rb[d], pc * u);
      chk("pass_nrounds", nr[d], pass_n(u, ver, pc));
      chk("pass_last", dp_last[d], (pc == np - 1) ? 1 : 0);
      chk("run_in_ready", in_ready[d], 0);
      chk("run_dp_load", dp_load[d], 0);
      chk("run_out_valid", out_valid[d], 0);
      chk("run_version", dp_version[d], ver);
      pc++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("pass_count_tbl", pc, exp_p);
    chk("pass_count_model", pc, np);
    out_ready[d] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("done_out_valid", out_valid[d], 1);
      chk("done_in_ready", in_ready[d], 0);
      chk("done_dp_load", dp_load[d], 0);
      chk("done_dp_step", dp_step[d], 0);
      chk("done_version", dp_version[d], ver);
      @(posedge clk); #1;
      @(negedge clk);
    end
    out_ready[d] = 1'b1;
    chk("done_out_valid", out_valid[d], 1);
    chk("done_busy", busy[d], 1);
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    chk("post_out_valid", out_valid[d], 0);
    chk("post_in_ready", in_ready[d], 1);
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 0, 1'b0, 3};
    tbl[1] = '{0, 1'b1, 0, 1'b0, 4};
    tbl[2] = '{0, 1'b0, 7, 1'b1, 3};
    tbl[3] = '{1, 1'b1, 2, 1'b0, 2};
    tbl[4] = '{1, 1'b0, 0, 1'b1, 2};
    tbl[5] = '{2, 1'b1, 1, 1'b0, 31};
    tbl[6] = '{2, 1'b0, 0, 1'b1, 25};
    tbl[7] = '{0, 1'b1, 3, 1'b1, 4};

    reset      = 1'b0;
    in_valid   = '0;
    in_version = '0;
    out_ready  = '0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 3'b111);
    chk("rst_busy", busy, 3'b000);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 3'b111);
      chk("idle_out_valid", out_valid, 3'b000);
      chk("idle_dp_load", dp_load, 3'b000);
      chk("idle_dp_step", dp_step, 3'b000);
      chk("idle_busy", busy, 3'b000);
      chk("idle_version", dp_version, 3'b000);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].d, tbl[i].ver, tbl[i].hold,
              tbl[i].noise, tbl[i].exp_p);
    end

    // back-to-back on the 9-round instance
    run_req(0, 1'b0, 0, 1'b1, 3);
    run_req(0, 1'b0, 0, 1'b1, 3);

    for (int i = 0; i < 20; i++) begin
      int d;
      bit v;
      d = int'($urandom_range(0, 2));
      v = 1'($urandom_range(0, 1));
      run_req(d, v, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)),
              n_passes(unroll_of(d), v));
    end

    // reset during the second pass
    in_valid[0]   = 1'b1;
    in_version[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_base", rb[0], 9);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_in_ready", in_ready[0], 1);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_step", dp_step[0], 0);
    chk("rst_mid_version", dp_version[0], 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid[0], 0);
      chk("post_rst_busy", busy[0], 0);
    end
    @(posedge clk); #1;
    run_req(0, 1'b1, 0, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
